i2c_reg_responder: RTL and testbench



---
 rtl/i2c_reg_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_i2c_reg_responder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_responder.sv
// I2C target register responder: acknowledges DEV_ADDR, takes a register pointer byte,
// then writes incoming bytes to or streams bytes from a host register file, auto-incrementing.
module i2c_reg_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h68,
    parameter int         PTR_W    = 7
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             iSCL,
    input  logic             iSDA,
    output logic             oSDA_LOW,
    output logic [PTR_W-1:0] REG_ADDR,
    output logic [7:0]       REG_WDATA,
    output logic             REG_WE,
    output logic             REG_RE,
    input  logic [7:0]       REG_RDATA,
    output logic             BUSY
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ADDR_ACK  = 4'd2,
        PTR       = 4'd3,
        PTR_ACK   = 4'd4,
        WDATA     = 4'd5,
        WDATA_ACK = 4'd6,
        RDATA     = 4'd7,
        RDATA_ACK = 4'd8,
        WAIT_STOP = 4'd9
    } state_t;

    // [0] first sync stage, [1] second sync stage, [2] previous value
    logic [2:0]       scl_sync_q, sda_sync_q;
    logic             scl_rise_q, scl_fall_q, start_q, stop_q, sda_bit_q;

    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             ack_phase_q, ack_phase_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             we_q, we_d;
    logic             re_q, re_d;
    logic             sda_low_q, sda_low_d;
    logic             busy_q, busy_d;
    logic [7:0]       byte_in_s;

    assign byte_in_s = {shift_q[6:0], sda_bit_q};

    // Synchronise the bus pins and register the edge and START/STOP events
    always_ff @(posedge CLK) begin
        if (reset) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            sda_bit_q  <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], iSCL};
            sda_sync_q <= {sda_sync_q[1:0], iSDA};
            scl_rise_q <= scl_sync_q[1] & ~scl_sync_q[2];
            scl_fall_q <= ~scl_sync_q[1] & scl_sync_q[2];
            start_q    <= scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[1] & sda_sync_q[2];
            stop_q     <= scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[1] & ~sda_sync_q[2];
            sda_bit_q  <= sda_sync_q[1];
        end
    end

    // Protocol next-state logic; START/STOP take priority over any clock event
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ack_phase_d = ack_phase_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        re_d        = 1'b0;
        sda_low_d   = sda_low_q;
        busy_d      = busy_q;

        if (we_q || re_q) begin
            ptr_d = ptr_q + PTR_W'(1);
        end else begin
            ptr_d = ptr_q;
        end

        // Read data is valid alongside the strobe, so bit 7 goes out one cycle after it
        if (re_q && (state_q == RDATA)) begin
            shift_d   = REG_RDATA;
            sda_low_d = ~REG_RDATA[7];
        end else begin
            shift_d = shift_q;
        end

        if (stop_q) begin
            state_d     = IDLE;
            sda_low_d   = 1'b0;
            busy_d      = 1'b0;
            ack_phase_d = 1'b0;
        end else if (start_q) begin
            state_d     = ADDR;
            bit_cnt_d   = 3'd0;
            sda_low_d   = 1'b0;
            ack_phase_d = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise_q) begin
                        shift_d   = byte_in_s;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ack_phase_d = 1'b0;
                            case (state_q)
                                ADDR: begin
                                    if (byte_in_s[7:1] == DEV_ADDR) begin
                                        state_d = ADDR_ACK;
                                        busy_d  = 1'b1;
                                    end else begin
                                        state_d = IDLE;
                                        busy_d  = 1'b0;
                                    end
                                end
                                PTR: begin
                                    ptr_d   = byte_in_s[PTR_W-1:0];
                                    state_d = PTR_ACK;
                                end
                                default: begin
                                    wdata_d = byte_in_s;
                                    we_d    = 1'b1;
                                    state_d = WDATA_ACK;
                                end
                            endcase
                        end else begin
                            ack_phase_d = ack_phase_q;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                // First scl_fall drives the ACK, the second one ends the ACK bit
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall_q && !ack_phase_q) begin
                        sda_low_d   = 1'b1;
                        ack_phase_d = 1'b1;
                    end else if (scl_fall_q) begin
                        sda_low_d   = 1'b0;
                        ack_phase_d = 1'b0;
                        bit_cnt_d   = 3'd0;
                        if (state_q != ADDR_ACK) begin
                            state_d = WDATA;
                        end else if (shift_q[0]) begin
                            re_d    = 1'b1;
                            state_d = RDATA;
                        end else begin
                            state_d = PTR;
                        end
                    end else begin
                        ack_phase_d = ack_phase_q;
                    end
                end
                RDATA: begin
                    if (scl_fall_q) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_low_d = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = RDATA_ACK;
                        end else begin
                            sda_low_d = ~shift_q[6];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                RDATA_ACK: begin
                    if (scl_rise_q) begin
                        state_d = sda_bit_q ? WAIT_STOP : RDATA_ACK;
                    end else if (scl_fall_q) begin
                        re_d      = 1'b1;
                        bit_cnt_d = 3'd0;
                        state_d   = RDATA;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Protocol state and registered outputs
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            ack_phase_q <= 1'b0;
            ptr_q       <= '0;
            wdata_q     <= 8'h00;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            sda_low_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ack_phase_q <= ack_phase_d;
            ptr_q       <= ptr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            re_q        <= re_d;
            sda_low_q   <= sda_low_d;
            busy_q      <= busy_d;
        end
    end

    assign oSDA_LOW  = sda_low_q;
    assign REG_ADDR  = ptr_q;
    assign REG_WDATA = wdata_q;
    assign REG_WE    = we_q;
    assign REG_RE    = re_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_i2c_reg_responder.sv
// Bench for i2c_reg_responder: a bit-banged I2C master, a register-file model and a
// strobe scoreboard checked by an independent monitor.
module tb_i2c_reg_responder;

    typedef struct packed {
        logic       we;
        logic [6:0] addr;
        logic [7:0] data;
    } strobe_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       scl   = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       oSDA_LOW, REG_WE, REG_RE, BUSY;
    logic [6:0] REG_ADDR;
    logic [7:0] REG_WDATA, REG_RDATA;

    logic [7:0] dut_file [128];
    logic [7:0] mmem     [128];
    int         mptr;
    int         tests = 0;
    int         fails = 0;
    int         drive_cnt = 0;
    strobe_t    exp_q [$];
    strobe_t    mon_act, mon_exp;

    always #5 clk = ~clk;

    assign sda_bus   = sda_m & ~oSDA_LOW;
    assign REG_RDATA = dut_file[REG_ADDR];

    i2c_reg_responder #(.DEV_ADDR(7'h68), .PTR_W(7)) dut (
        .CLK      (clk),
        .reset    (reset),
        .iSCL     (scl),
        .iSDA     (sda_bus),
        .oSDA_LOW (oSDA_LOW),
        .REG_ADDR (REG_ADDR),
        .REG_WDATA(REG_WDATA),
        .REG_WE   (REG_WE),
        .REG_RE   (REG_RE),
        .REG_RDATA(REG_RDATA),
        .BUSY     (BUSY)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Host-side register file: loaded from the model on reset, written by REG_WE
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) dut_file[i] <= mmem[i];
        end else if (REG_WE) begin
            dut_file[REG_ADDR] <= REG_WDATA;
        end
    end

    // Monitor: every strobe pops the next expected strobe from the scoreboard
    always @(negedge clk) begin
        if (oSDA_LOW) drive_cnt++;
        if (REG_WE || REG_RE) begin
            mon_act.we   = REG_WE;
            mon_act.addr = REG_ADDR;
            mon_act.data = REG_WE ? REG_WDATA : 8'h00;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL strobe_unexpected: got we=%0d addr=%0h data=%0h, required no strobe",
                         mon_act.we, mon_act.addr, mon_act.data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("strobe", 32'(mon_act), 32'(mon_exp));
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Each bit starts just after SCL fell; SCL low and high phases are 10 CLK each
    task automatic write_bit(input logic b);
        wait_clk(3); sda_m = b;
        wait_clk(7); scl = 1'b1;
        wait_clk(10); scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        wait_clk(3); sda_m = 1'b1;
        wait_clk(7); scl = 1'b1;
        wait_clk(5); b = sda_bus;
        wait_clk(5); scl = 1'b0;
    endtask

    task automatic bus_start();
        wait_clk(3); sda_m = 1'b1;
        wait_clk(7); scl = 1'b1;
        wait_clk(10); sda_m = 1'b0;
        wait_clk(10); scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(3); sda_m = 1'b0;
        wait_clk(7); scl = 1'b1;
        wait_clk(10); sda_m = 1'b1;
        wait_clk(10);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~master_ack);
    endtask

    task automatic t_addr_ptr(input logic [7:0] p);
        logic ack;
        bus_start();
        write_byte(8'hD0, ack);
        check("addr_ack", 32'(ack), 32'd1);
        check("busy_set", 32'(BUSY), 32'd1);
        write_byte(p, ack);
        check("ptr_ack", 32'(ack), 32'd1);
        mptr = int'(p) % 128;
    endtask

    task automatic t_wdata(input logic [7:0] d);
        logic    ack;
        strobe_t s;
        s.we = 1'b1; s.addr = 7'(mptr); s.data = d;
        exp_q.push_back(s);
        mmem[mptr] = d;
        mptr = (mptr + 1) % 128;
        write_byte(d, ack);
        check("data_ack", 32'(ack), 32'd1);
    endtask

    task automatic t_read(input int n);
        logic       ack;
        logic [7:0] got, want;
        strobe_t    s;
        bus_start();
        write_byte(8'hD1, ack);
        check("rd_addr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < n; i++) begin
            want = mmem[mptr];
            s.we = 1'b0; s.addr = 7'(mptr); s.data = 8'h00;
            exp_q.push_back(s);
            mptr = (mptr + 1) % 128;
            read_byte(i != n - 1, got);
            check("rd_data", 32'(got), 32'(want));
        end
        bus_stop();
    endtask

    initial begin
        logic       ack, b;
        int         d0, n;
        logic [7:0] p;
        strobe_t    s;

        for (int i = 0; i < 128; i++) mmem[i] = 8'($urandom);
        mmem[8'h75] = 8'h71;
        mptr = 0;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(1);
        check("rst_sda",   32'(oSDA_LOW),  32'd0);
        check("rst_we",    32'(REG_WE),    32'd0);
        check("rst_re",    32'(REG_RE),    32'd0);
        check("rst_addr",  32'(REG_ADDR),  32'd0);
        check("rst_wdata", 32'(REG_WDATA), 32'd0);
        check("rst_busy",  32'(BUSY),      32'd0);
        wait_clk(10);

        // Two-byte write from 0x6B
        t_addr_ptr(8'h6B);
        t_wdata(8'h01);
        t_wdata(8'h02);
        bus_stop();
        wait_clk(10);
        check("wr_final_ptr", 32'(REG_ADDR), 32'h6D);
        check("wr_busy_low",  32'(BUSY),     32'd0);

        // Pointer write then repeated-START read of 0x75
        t_addr_ptr(8'h75);
        t_read(1);
        wait_clk(10);
        check("rd_final_ptr", 32'(REG_ADDR), 32'(mptr));
        check("rd_busy_low",  32'(BUSY),     32'd0);

        // Foreign address 0x69 is ignored completely
        d0 = drive_cnt;
        bus_start();
        write_byte(8'hD2, ack);
        check("foreign_nack", 32'(ack),  32'd0);
        check("foreign_busy", 32'(BUSY), 32'd0);
        bus_stop();
        wait_clk(10);
        check("foreign_no_drive", 32'(drive_cnt - d0), 32'd0);
        check("foreign_ptr",      32'(REG_ADDR),       32'(mptr));

        // Burst read across the wrap; pointer byte upper bit must be ignored
        t_addr_ptr(8'hFF);
        t_read(2);
        wait_clk(10);
        check("wrap_ptr", 32'(REG_ADDR), 32'(mptr));

        // Randomised write bursts read back from the same pointer
        for (int it = 0; it < 6; it++) begin
            p = 8'($urandom);
            n = int'($urandom_range(1, 3));
            t_addr_ptr(p);
            for (int k = 0; k < n; k++) t_wdata(8'($urandom));
            bus_stop();
            t_addr_ptr(p);
            t_read(n + 1);
            wait_clk(10);
            check("rand_ptr", 32'(REG_ADDR), 32'(mptr));
        end

        // STOP after half a data byte discards it
        t_addr_ptr(8'h33);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        bus_stop();
        wait_clk(10);
        check("partial_ptr",  32'(REG_ADDR), 32'h33);
        check("partial_busy", 32'(BUSY),     32'd0);
        check("partial_sda",  32'(oSDA_LOW), 32'd0);

        // Reset while the responder drives a zero data bit
        t_addr_ptr(8'h20);
        t_wdata(8'h00);
        bus_stop();
        t_addr_ptr(8'h20);
        bus_start();
        write_byte(8'hD1, ack);
        check("rst_rd_addr_ack", 32'(ack), 32'd1);
        s.we = 1'b0; s.addr = 7'h20; s.data = 8'h00;
        exp_q.push_back(s);
        for (int k = 0; k < 3; k++) begin
            read_bit(b);
            check("rst_rd_bit", 32'(b), 32'd0);
        end
        wait_clk(3); sda_m = 1'b1;
        wait_clk(7); scl = 1'b1;
        wait_clk(5);
        check("drive_before_reset", 32'(oSDA_LOW), 32'd1);
        reset = 1'b1;
        wait_clk(1);
        check("reset_release", 32'(oSDA_LOW), 32'd0);
        wait_clk(3);
        reset = 1'b0;
        mptr = 0;
        wait_clk(1);
        check("reset_ptr",  32'(REG_ADDR), 32'd0);
        check("reset_busy", 32'(BUSY),     32'd0);
        wait_clk(5); scl = 1'b0;
        wait_clk(10);
        t_addr_ptr(8'h41);
        t_wdata(8'h5A);
        bus_stop();
        wait_clk(10);
        check("post_reset_ptr", 32'(REG_ADDR), 32'(mptr));

        wait_clk(20);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
